// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge
//   Bridges the CPU valid/ready memory port onto a multiplexed external
//   address/data bus (SRAM, latched peripherals). One 32-bit access runs as
//   NA address phases followed by NB data beats. Each data beat lasts
//   1+WAIT_CYC cycles. Reads are followed by TURN_CYC idle cycles so the pads
//   can turn around.
//
// Parameters
//   BUS_W    external bus width (8, 16 or 32)
//   ADDR_W   address bits driven on the bus (multiple of BUS_W, at most 32)
//   WAIT_CYC extra cycles per data beat (0..15)
//   TURN_CYC idle cycles after a read (0..3)
//
// Ports
//   clk, reset  clock; asynchronous active-high reset
//   valid/ready CPU request (held until ready) / one-cycle completion pulse
//   rw          1=write, 0=read
//   addri       word address
//   be          byte enables (be[i] = byte i)
//   dtw         write data
//   dtr         read data
//   din/dout    bus in from pads / bus out to pads
//   isout       pad output enable
//   ale         per-slice address latch strobes
//   oe, we      read / write strobes
//   lane_en     byte-lane enables for the current beat
//   beat        current beat index
//   wait_n      external wait (only when EXT_WAIT_EN is defined)
//
// Optional feature: define EXT_WAIT_EN to add wait_n. Driving wait_n low on
// the last cycle of a data beat stretches that beat.
module ext_bus_bridge #(
    parameter int unsigned BUS_W    = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned WAIT_CYC = 1,
    parameter int unsigned TURN_CYC = 1,
    localparam int unsigned NA = ADDR_W / BUS_W,
    localparam int unsigned NB = 32 / BUS_W,
    localparam int unsigned L  = BUS_W / 8,
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic             rw,
    input  logic [31:0]      addri,
    input  logic [3:0]       be,
    input  logic [31:0]      dtw,
    output logic [31:0]      dtr,
    input  logic [BUS_W-1:0] din,
    output logic [BUS_W-1:0] dout,
    output logic             isout,
    output logic [NA-1:0]    ale,
    output logic             oe,
    output logic             we,
    output logic [L-1:0]     lane_en,
    output logic [BW-1:0]    beat
`ifdef EXT_WAIT_EN
    ,
    input  logic             wait_n
`endif
);

    localparam int unsigned PW    = (NA > 1) ? $clog2(NA) : 1;
    localparam logic [3:0]  WLAST = 4'(WAIT_CYC);
    localparam logic [1:0]  TLAST = 2'(TURN_CYC - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StData, StDone, StTurn} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [3:0]        r_be;
    logic [31:0]       r_dtw;
    logic [PW-1:0]     r_phase;
    logic [BW-1:0]     r_beat;
    logic [3:0]        r_wcnt;
    logic [1:0]        r_tcnt;

    logic              r_ready;
    logic              r_isout;
    logic [NA-1:0]     r_ale;
    logic              r_oe;
    logic              r_we;
    logic [L-1:0]      r_lane_en;
    logic [BUS_W-1:0]  r_dout;
    logic [31:0]       r_dtr;

    logic              w_go;
    logic              w_last;
    logic              w_load_beat;
    logic [PW-1:0]     w_phase_nxt;
    logic [BW-1:0]     w_nb;
    logic [L-1:0]      w_nb_lanes;
    logic [BUS_W-1:0]  w_nb_dout;
    logic [BUS_W-1:0]  w_rd_data;

`ifdef EXT_WAIT_EN
    assign w_go = wait_n;
`else
    assign w_go = 1'b1;
`endif

    assign w_last      = (r_wcnt == WLAST);
    assign w_phase_nxt = r_phase + PW'(1);

    // A new beat starts after the last address phase, or when a non-final beat ends.
    assign w_load_beat = ((r_state == StAddr) && (r_phase == PW'(NA - 1))) ||
                         ((r_state == StData) && w_last && w_go && (r_beat != BW'(NB - 1)));

    always_comb begin
        w_nb       = (r_state == StData) ? r_beat + BW'(1) : '0;
        w_nb_lanes = r_be[w_nb*L +: L];
        w_nb_dout  = r_dtw[w_nb*BUS_W +: BUS_W];
    end

    // Disabled lanes read back as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < int'(L); i++) begin
            if (r_lane_en[i]) begin
                w_rd_data[i*8 +: 8] = din[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_be      <= '0;
            r_dtw     <= '0;
            r_phase   <= '0;
            r_beat    <= '0;
            r_wcnt    <= '0;
            r_tcnt    <= '0;
            r_ready   <= 1'b0;
            r_isout   <= 1'b0;
            r_ale     <= '0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_lane_en <= '0;
            r_dout    <= '0;
            r_dtr     <= '0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (valid) begin
                        r_state <= StAddr;
                        r_addr  <= addri[ADDR_W-1:0];
                        r_rw    <= rw;
                        r_be    <= be;
                        r_dtw   <= dtw;
                        r_phase <= '0;
                        r_ale   <= NA'(1);
                        r_isout <= 1'b1;
                        r_dout  <= addri[BUS_W-1:0];
                    end
                end
                StAddr: begin
                    if (r_phase == PW'(NA - 1)) begin
                        r_state <= StData;
                        r_ale   <= '0;
                    end else begin
                        r_phase <= w_phase_nxt;
                        r_ale   <= r_ale << 1;
                        r_dout  <= r_addr[w_phase_nxt*BUS_W +: BUS_W];
                    end
                end
                StData: begin
                    if (!w_last) begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end else if (w_go) begin
                        if (!r_rw) begin
                            r_dtr[r_beat*BUS_W +: BUS_W] <= w_rd_data;
                        end
                        if (r_beat == BW'(NB - 1)) begin
                            r_state   <= StDone;
                            r_ready   <= 1'b1;
                            r_isout   <= 1'b0;
                            r_oe      <= 1'b0;
                            r_we      <= 1'b0;
                            r_lane_en <= '0;
                            r_dout    <= '0;
                            r_beat    <= '0;
                        end
                    end
                    // wait_n low on a last cycle: everything holds.
                end
                StDone: begin
                    r_tcnt  <= '0;
                    r_state <= (!r_rw && (TURN_CYC > 0)) ? StTurn : StIdle;
                end
                StTurn: begin
                    if (r_tcnt == TLAST) begin
                        r_state <= StIdle;
                    end else begin
                        r_tcnt <= r_tcnt + 2'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase

            if (w_load_beat) begin
                r_beat    <= w_nb;
                r_wcnt    <= '0;
                r_lane_en <= w_nb_lanes;
                r_isout   <= r_rw;
                r_we      <= r_rw & (|w_nb_lanes);
                r_oe      <= ~r_rw & (|w_nb_lanes);
                r_dout    <= r_rw ? w_nb_dout : '0;
            end
        end
    end

    assign ready   = r_ready;
    assign isout   = r_isout;
    assign ale     = r_ale;
    assign oe      = r_oe;
    assign we      = r_we;
    assign lane_en = r_lane_en;
    assign beat    = r_beat;
    assign dout    = r_dout;
    assign dtr     = r_dtr;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Bench for ext_bus_bridge: directed transactions with literal expectations,
// an asynchronous reset abort, then randomized back-to-back traffic compared
// cycle by cycle against an expected trace built from the bus protocol rules.
`timescale 1ns/1ps
module tb_ext_bus_bridge;

    localparam int unsigned BUS_W    = 16;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WAIT_CYC = 1;
    localparam int unsigned TURN_CYC = 1;
    localparam int unsigned NA = ADDR_W / BUS_W;
    localparam int unsigned NB = 32 / BUS_W;
    localparam int unsigned L  = BUS_W / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

    typedef struct {
        logic [NA-1:0]    ale;
        logic             oe;
        logic             we;
        logic             isout;
        logic             ready;
        logic [BUS_W-1:0] dout;
        logic             chk_dout;
        logic [L-1:0]     lane_en;
        logic [BW-1:0]    beat;
        logic             chk_lane;
        logic [31:0]      dtr;
        logic             chk_dtr;
    } exp_t;

    typedef struct {
        logic             valid;
        logic             rw;
        logic [31:0]      addri;
        logic [31:0]      dtw;
        logic [3:0]       be;
        logic [BUS_W-1:0] din;
        logic             wait_n;
        exp_t             e;
    } step_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             valid = 1'b0;
    logic             rw = 1'b0;
    logic [31:0]      addri = '0;
    logic [3:0]       be = '0;
    logic [31:0]      dtw = '0;
    logic [BUS_W-1:0] din = '0;
    logic             wait_n = 1'b1;
    logic             ready;
    logic [31:0]      dtr;
    logic [BUS_W-1:0] dout;
    logic             isout;
    logic [NA-1:0]    ale;
    logic             oe;
    logic             we;
    logic [L-1:0]     lane_en;
    logic [BW-1:0]    beat;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] exp_dtr = '0;
    exp_t exp_q[$];

    logic [NA-1:0]    h_ale   [256];
    logic             h_oe    [256];
    logic             h_we    [256];
    logic             h_isout [256];
    logic             h_ready [256];
    logic [BUS_W-1:0] h_dout  [256];
    logic [L-1:0]     h_lane  [256];
    logic [BW-1:0]    h_beat  [256];
    logic [31:0]      h_dtr   [256];

    ext_bus_bridge #(
        .BUS_W    (BUS_W),
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .ready   (ready),
        .rw      (rw),
        .addri   (addri),
        .be      (be),
        .dtw     (dtw),
        .dtr     (dtr),
        .din     (din),
        .dout    (dout),
        .isout   (isout),
        .ale     (ale),
        .oe      (oe),
        .we      (we),
        .lane_en (lane_en),
        .beat    (beat)
`ifdef EXT_WAIT_EN
        ,
        .wait_n  (wait_n)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e.ale = '0; e.oe = 1'b0; e.we = 1'b0; e.isout = 1'b0; e.ready = 1'b0;
        e.dout = '0; e.chk_dout = 1'b0;
        e.lane_en = '0; e.beat = '0; e.chk_lane = 1'b0;
        e.dtr = exp_dtr; e.chk_dtr = 1'b1;
        return e;
    endfunction

    // Random request fields on every cycle: the bridge must only use what it latched.
    function automatic step_t rand_step();
        step_t s;
        s.valid  = 1'($urandom);
        s.rw     = 1'($urandom);
        s.addri  = $urandom;
        s.dtw    = $urandom;
        s.be     = 4'($urandom);
        s.din    = BUS_W'($urandom);
        s.wait_n = 1'b1;
        s.e      = idle_e();
        return s;
    endfunction

    // Compare process: every cycle with an expectation queued is checked.
    always @(negedge clk) begin
        exp_t ce;
        h_ale[cyc[7:0]]   = ale;
        h_oe[cyc[7:0]]    = oe;
        h_we[cyc[7:0]]    = we;
        h_isout[cyc[7:0]] = isout;
        h_ready[cyc[7:0]] = ready;
        h_dout[cyc[7:0]]  = dout;
        h_lane[cyc[7:0]]  = lane_en;
        h_beat[cyc[7:0]]  = beat;
        h_dtr[cyc[7:0]]   = dtr;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk("ctrl{ale,oe,we,isout,ready}", 32'({ale, oe, we, isout, ready}),
                32'({ce.ale, ce.oe, ce.we, ce.isout, ce.ready}));
            if (ce.chk_dout) chk("dout", 32'(dout), 32'(ce.dout));
            if (ce.chk_lane) chk("lane_en/beat", 32'({lane_en, beat}), 32'({ce.lane_en, ce.beat}));
            if (ce.chk_dtr) chk("dtr", dtr, ce.dtr);
        end
    end

    // Builds the expected trace for one access (gap idle cycles, then the access),
    // replays it and optionally aborts it with reset at trace index abort_at.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] wd, input logic [31:0] rdd, input int gap,
                           input int abort_at, output int t0);
        step_t       q[$];
        step_t       s;
        logic [31:0] nd;
        int          ncyc;
        int          stall;
        t0 = 0;
        for (int g = 0; g < gap; g++) begin
            s = rand_step();
            s.valid = 1'b0;
            q.push_back(s);
        end
        s = rand_step();
        s.valid = 1'b1; s.rw = wr; s.addri = a; s.be = b; s.dtw = wd;
        q.push_back(s);
        for (int k = 0; k < int'(NA); k++) begin
            s = rand_step();
            s.e.ale = NA'(1) << k;
            s.e.isout = 1'b1;
            s.e.dout = a[k*BUS_W +: BUS_W];
            s.e.chk_dout = 1'b1;
            q.push_back(s);
        end
        nd = '0;
        ncyc = 1 + int'(WAIT_CYC);
        for (int bb = 0; bb < int'(NB); bb++) begin
            logic [L-1:0]     lanes;
            logic [BUS_W-1:0] rdv;
            lanes = b[bb*L +: L];
            rdv = rdd[bb*BUS_W +: BUS_W];
`ifdef EXT_WAIT_EN
            stall = int'($urandom_range(0, 2));
`else
            stall = 0;
`endif
            for (int c = 0; c < ncyc + stall; c++) begin
                s = rand_step();
                s.e.isout = wr;
                s.e.we = wr && (lanes != '0);
                s.e.oe = !wr && (lanes != '0);
                s.e.lane_en = lanes;
                s.e.beat = BW'(bb);
                s.e.chk_lane = 1'b1;
                s.e.dout = wd[bb*BUS_W +: BUS_W];
                s.e.chk_dout = wr;
                s.e.chk_dtr = wr;
                if (c == ncyc + stall - 1) begin
                    s.wait_n = 1'b1;
                    s.din = rdv;
                end else if (c >= ncyc - 1) begin
                    s.wait_n = 1'b0;
                end else begin
                    s.wait_n = 1'($urandom);
                end
                q.push_back(s);
            end
            for (int l = 0; l < int'(L); l++) begin
                nd[(bb*L + l)*8 +: 8] = b[bb*L + l] ? rdv[l*8 +: 8] : 8'h00;
            end
        end
        if (!wr) exp_dtr = nd;
        s = rand_step();
        s.e.ready = 1'b1;
        q.push_back(s);
        if (!wr) begin
            for (int t = 0; t < int'(TURN_CYC); t++) q.push_back(rand_step());
        end

        foreach (q[i]) begin
            @(posedge clk);
            #1;
            cyc++;
            if (i == gap) t0 = cyc;
            if (i == abort_at) begin
                chk("abort_we_before_reset", 32'(we), 32'(wr));
                valid = 1'b0;
                reset = 1'b1;
                #1;
                chk("abort_async_drop", 32'({ale, oe, we, isout, ready}), 32'd0);
                exp_dtr = '0;
                exp_q.push_back(idle_e());
                repeat (2) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    exp_q.push_back(idle_e());
                end
                @(posedge clk);
                #1;
                cyc++;
                reset = 1'b0;
                exp_q.push_back(idle_e());
                @(negedge clk);
                #1;
                return;
            end
            valid  = q[i].valid;
            rw     = q[i].rw;
            addri  = q[i].addri;
            be     = q[i].be;
            dtw    = q[i].dtw;
            din    = q[i].din;
            wait_n = q[i].wait_n;
            exp_q.push_back(q[i].e);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int tr;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({ale, oe, we, isout, ready}), 32'd0);
        chk("reset_lane_beat", 32'({lane_en, beat}), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_dtr", dtr, 32'd0);
        reset = 1'b0;

        // Write 0xDEADBEEF @0x1234, all lanes.
        run_txn(1'b1, 32'h0000_1234, 4'hF, 32'hDEAD_BEEF, 32'h0, 1, -1, t0);
        chk("t1_ale0", 32'(h_ale[8'(t0+1)]), 32'b01);
        chk("t1_addr_lo", 32'(h_dout[8'(t0+1)]), 32'h1234);
        chk("t1_ale1", 32'(h_ale[8'(t0+2)]), 32'b10);
        chk("t1_addr_hi", 32'(h_dout[8'(t0+2)]), 32'h0000);
        chk("t1_beat0_data", 32'({h_we[8'(t0+4)], h_beat[8'(t0+4)], h_lane[8'(t0+4)],
            h_dout[8'(t0+3)]}), {13'd0, 1'b1, 1'b0, 2'b11, 16'hBEEF});
        chk("t1_beat1_data", 32'({h_we[8'(t0+5)], h_beat[8'(t0+6)], h_dout[8'(t0+5)]}),
            {14'd0, 1'b1, 1'b1, 16'hDEAD});
        chk("t1_ready_c6", 32'(h_ready[8'(t0+6)]), 32'd0);
        chk("t1_ready_c7", 32'(h_ready[8'(t0+7)]), 32'd1);

        // Read @0x10 with beat data 5678 then 1234, immediately followed by a write.
        run_txn(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'h1234_5678, 0, -1, tr);
        chk("t2_dtr", h_dtr[8'(tr+7)], 32'h1234_5678);
        chk("t2_ready", 32'(h_ready[8'(tr+7)]), 32'd1);
        chk("t2_isout_data", 32'({h_isout[8'(tr+3)], h_isout[8'(tr+4)], h_isout[8'(tr+5)],
            h_isout[8'(tr+6)]}), 32'd0);
        chk("t2_oe", 32'({h_oe[8'(tr+3)], h_oe[8'(tr+6)]}), 32'b11);
        run_txn(1'b1, 32'h0000_0020, 4'b1100, 32'hCAFE_F00D, 32'h0, 0, -1, t0);
        chk("t2_turn_idle", 32'({h_ale[8'(tr+8)], h_ale[8'(tr+9)]}), 32'd0);
        chk("t2_accept_c9", 32'(h_ale[8'(tr+10)]), 32'b01);
        chk("t3_beat0_off", 32'({h_we[8'(t0+3)], h_lane[8'(t0+3)]}), 32'd0);
        chk("t3_beat1_on", 32'({h_we[8'(t0+5)], h_lane[8'(t0+5)]}), 32'b111);
        chk("t3_ready_c7", 32'(h_ready[8'(t0+7)]), 32'd1);
        chk("t3_dtr_kept", h_dtr[8'(t0+7)], 32'h1234_5678);

        // Reset during the c4 data cycle of a write, then a normal read.
        run_txn(1'b1, 32'hA5A5_5A5A, 4'hF, 32'h0BAD_F00D, 32'h0, 1, 5, t0);
        run_txn(1'b0, 32'h0000_0044, 4'b0110, 32'h0, 32'h89AB_CDEF, 0, -1, t0);
        chk("t4_read_after_reset", h_dtr[8'(t0+7)], 32'h00AB_CD00);

        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 2)), -1, t0);
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL trace_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
